divider_10b: RTL and testbench

Sequential unsigned fixed-point divider for 10-bit Q4.6 operands (4 integer bits, 6 fractional bits). It computes Q = A / B one quotient bit per clock with a restoring shift-subtract datapath. A start/busy/valid handshake connects it to a host controller, and it flags divide-by-zero and overflow.

---
 rtl/divider_10b.sv | 162 ++++++++++++++++
 tb/tb_divider_10b.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/divider_10b.sv
// divider_10b: sequential unsigned Q4.6 restoring divider, one quotient bit per clock.
// Optional feature macro: DIVIDER_ROUND_EN (adds a guard-bit iteration and rounds half-up).
module divider_10b (
   input  logic [9:0] A,
   input  logic [9:0] B,
   output logic [9:0] Q,
   input  logic       reset,
   input  logic       start,
   input  logic       clock,
   output logic       busy,
   output logic       dvz,
   output logic       ovf,
   output logic       valid
);

   localparam int unsigned W     = 10;
`ifdef DIVIDER_ROUND_EN
   localparam int unsigned NITER = 17;
`else
   localparam int unsigned NITER = 16;
`endif
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           r_state, w_state;
   logic [NITER-1:0] r_dvd,   w_dvd;
   logic [W-1:0]     r_div,   w_div;
   logic [W:0]       r_rem,   w_rem;
   logic [NITER-1:0] r_quo,   w_quo;
   logic [CNT_W-1:0] r_cnt,   w_cnt;
   logic             r_wait,  w_wait;
   logic [W-1:0]     r_q,     w_q;
   logic             r_busy,  w_busy;
   logic             r_dvz,   w_dvz;
   logic             r_ovf,   w_ovf;
   logic             r_valid, w_valid;

   logic [W:0]       w_rem_sh;
   logic             w_ge;
   logic [W:0]       w_rem_sub;
   logic [NITER-1:0] w_res;
   logic             w_res_ovf;

   // One restoring step: shift in next dividend bit, trial-subtract the divisor.
   assign w_rem_sh  = (W+1)'({r_rem, r_dvd[NITER-1]});
   assign w_ge      = (w_rem_sh >= {1'b0, r_div});
   assign w_rem_sub = w_rem_sh - {1'b0, r_div};

   // Final quotient: guard bit rounds half-up when rounding is built in.
`ifdef DIVIDER_ROUND_EN
   assign w_res = {1'b0, r_quo[NITER-1:1]} + NITER'(r_quo[0]);
`else
   assign w_res = r_quo;
`endif
   assign w_res_ovf = |w_res[NITER-1:W];

   // Next-state, datapath and registered-output update.
   always_comb begin
      w_state = r_state;
      w_dvd   = r_dvd;
      w_div   = r_div;
      w_rem   = r_rem;
      w_quo   = r_quo;
      w_cnt   = r_cnt;
      w_wait  = r_wait;
      w_q     = r_q;
      w_busy  = r_busy;
      w_dvz   = r_dvz;
      w_ovf   = r_ovf;
      w_valid = r_valid;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_dvd   = {A, {(NITER-W){1'b0}}};
               w_div   = B;
               w_rem   = '0;
               w_quo   = '0;
               w_cnt   = '0;
               w_busy  = 1'b1;
               w_dvz   = 1'b0;
               w_ovf   = 1'b0;
               w_valid = 1'b0;
               if (B == '0) begin
                  // Zero divisor skips the iterations but still dwells one extra DONE cycle.
                  w_state = S_DONE;
                  w_wait  = 1'b1;
               end else begin
                  w_state = S_CALC;
                  w_wait  = 1'b0;
               end
            end
         end
         S_CALC: begin
            w_rem = w_ge ? w_rem_sub : w_rem_sh;
            w_quo = {r_quo[NITER-2:0], w_ge};
            w_dvd = {r_dvd[NITER-2:0], 1'b0};
            w_cnt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(NITER-1)) begin
               w_state = S_DONE;
            end
         end
         S_DONE: begin
            if (r_wait) begin
               w_wait = 1'b0;
            end else begin
               w_state = S_IDLE;
               w_busy  = 1'b0;
               if (r_div == '0) begin
                  w_dvz = 1'b1;
                  w_q   = '0;
               end else if (w_res_ovf) begin
                  w_ovf = 1'b1;
                  w_q   = {W{1'b1}};
               end else begin
                  w_valid = 1'b1;
                  w_q     = w_res[W-1:0];
               end
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   // State and output registers; reset forces IDLE and clears everything.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_dvd   <= '0;
         r_div   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_cnt   <= '0;
         r_wait  <= 1'b0;
         r_q     <= '0;
         r_busy  <= 1'b0;
         r_dvz   <= 1'b0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state;
         r_dvd   <= w_dvd;
         r_div   <= w_div;
         r_rem   <= w_rem;
         r_quo   <= w_quo;
         r_cnt   <= w_cnt;
         r_wait  <= w_wait;
         r_q     <= w_q;
         r_busy  <= w_busy;
         r_dvz   <= w_dvz;
         r_ovf   <= w_ovf;
         r_valid <= w_valid;
      end
   end

   assign Q     = r_q;
   assign busy  = r_busy;
   assign dvz   = r_dvz;
   assign ovf   = r_ovf;
   assign valid = r_valid;

endmodule

// File: tb/tb_divider_10b.sv
// tb_divider_10b: directed self-checking bench for divider_10b (honours DIVIDER_ROUND_EN).
module tb_divider_10b;

`ifdef DIVIDER_ROUND_EN
   localparam int LAT   = 18;
   localparam logic [9:0] Q_RND = 10'h02B;
`else
   localparam int LAT   = 17;
   localparam logic [9:0] Q_RND = 10'h02A;
`endif
   localparam int TMO = 100;

   logic [9:0] A, B, Q;
   logic       reset, start, clock, busy, dvz, ovf, valid;
   int         checks, errors;

   divider_10b dut (
      .A(A), .B(B), .Q(Q), .reset(reset), .start(start), .clock(clock),
      .busy(busy), .dvz(dvz), .ovf(ovf), .valid(valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pulse start (caller sits just after an edge), then count edges until busy drops.
   task automatic run_op(input logic [9:0] a, input logic [9:0] b, output int n);
      A = a; B = b; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      n = 0;
      do begin
         @(posedge clock); #1;
         n++;
      end while (busy && n < TMO);
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; A = '0; B = '0;
      @(posedge clock); #1;
      checks++; if (Q !== 10'h000) begin errors++; $display("FAIL reset_q got %h want 000", Q); end
      checks++; if ({busy, dvz, ovf, valid} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {busy, dvz, ovf, valid}); end
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_basic();
      int n;
      run_op(10'h320, 10'h190, n);
      checks++; if (n !== LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", n, LAT); end
      checks++; if (Q !== 10'h080) begin errors++; $display("FAIL basic_q got %h want 080", Q); end
      checks++; if ({valid, dvz, ovf} !== 3'b100) begin errors++; $display("FAIL basic_flags got %b want 100", {valid, dvz, ovf}); end
   endtask

   task automatic test_fraction();
      int n;
      run_op(10'h320, 10'h140, n);
      checks++; if (Q !== 10'h0A0) begin errors++; $display("FAIL frac_q got %h want 0A0", Q); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL frac_valid got %b want 1", valid); end
   endtask

   task automatic test_round();
      int n;
      run_op(10'h080, 10'h0C0, n);
      checks++; if (Q !== Q_RND) begin errors++; $display("FAIL round_q got %h want %h", Q, Q_RND); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL round_valid got %b want 1", valid); end
   endtask

   task automatic test_dvz();
      int n;
      run_op(10'h100, 10'h000, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL dvz_busy_cycles got %0d want 2", n); end
      checks++; if ({dvz, valid, ovf} !== 3'b100) begin errors++; $display("FAIL dvz_flags got %b want 100", {dvz, valid, ovf}); end
      checks++; if (Q !== 10'h000) begin errors++; $display("FAIL dvz_q got %h want 000", Q); end
   endtask

   task automatic test_ovf();
      int n;
      run_op(10'h3FF, 10'h001, n);
      checks++; if ({ovf, valid, dvz} !== 3'b100) begin errors++; $display("FAIL ovf_flags got %b want 100", {ovf, valid, dvz}); end
      checks++; if (Q !== 10'h3FF) begin errors++; $display("FAIL ovf_q got %h want 3FF", Q); end
   endtask

   task automatic test_back_to_back();
      int n;
      run_op(10'h320, 10'h190, n);
      A = 10'h320; B = 10'h140; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      checks++; if ({busy, valid} !== 2'b10) begin errors++; $display("FAIL b2b_accept got %b want 10", {busy, valid}); end
      n = 0;
      do begin @(posedge clock); #1; n++; end while (busy && n < TMO);
      checks++; if (Q !== 10'h0A0) begin errors++; $display("FAIL b2b_q got %h want 0A0", Q); end
   endtask

   task automatic test_busy_ignore();
      int n;
      A = 10'h320; B = 10'h190; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      A = 10'h080; B = 10'h0C0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      n = 4;
      do begin @(posedge clock); #1; n++; end while (busy && n < TMO);
      checks++; if (n !== LAT) begin errors++; $display("FAIL ignore_latency got %0d want %0d", n, LAT); end
      checks++; if (Q !== 10'h080) begin errors++; $display("FAIL ignore_q got %h want 080", Q); end
      @(posedge clock); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_relaunch got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      int n;
      A = 10'h3FF; B = 10'h001; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      checks++; if (Q !== 10'h000) begin errors++; $display("FAIL midrst_q got %h want 000", Q); end
      checks++; if ({busy, dvz, ovf, valid} !== 4'b0000) begin errors++; $display("FAIL midrst_flags got %b want 0000", {busy, dvz, ovf, valid}); end
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      run_op(10'h080, 10'h0C0, n);
      checks++; if (n !== LAT) begin errors++; $display("FAIL midrst_latency got %0d want %0d", n, LAT); end
      checks++; if ({Q, valid} !== {Q_RND, 1'b1}) begin errors++; $display("FAIL midrst_result got %h/%b want %h/1", Q, valid, Q_RND); end
   endtask

   initial begin
      checks = 0; errors = 0;
      test_reset();
      test_basic();
      test_fraction();
      test_round();
      test_dvz();
      test_ovf();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
